// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port with retry.
// Define FIFO_WR_ARB_STATS_EN to add the wr_count/retry_count outputs.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   wr_count,
  output logic [15:0]                   retry_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CHECK,
    RETRY
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST = IDX_W'(NUM_REQ - 1);

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      last_winner;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      idx;
  logic [NUM_REQ-1:0]    avail;
  logic [FIFO_WIDTH-1:0] hold;
  logic [FIFO_WIDTH-1:0] win_word;
  logic                  found;
  logic                  do_win;
  logic                  do_gnt;

  assign busy     = (state != IDLE);
  assign win_word = req_data[int'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];

  // search for the first request after the previous winner, wrapping
  always_comb begin
    avail   = req & ~gnt;
    found   = 1'b0;
    win_idx = '0;
    idx     = last_winner;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!found && avail[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // next state and the win/grant strobes
  always_comb begin
    state_nxt = state;
    do_win    = 1'b0;
    do_gnt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_full && found) begin
          state_nxt = WRITE;
          do_win    = 1'b1;
        end
      end
      WRITE: state_nxt = CHECK;
      CHECK: begin
        if (fifo_overflow || !fifo_wr_ack) begin
          state_nxt = RETRY;
        end else begin
          state_nxt = IDLE;
          do_gnt    = 1'b1;
        end
      end
      RETRY: begin
        if (!fifo_full) state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // capture the winner, drive the write port and the grant pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_winner  <= LAST;
      winner       <= '0;
      hold         <= '0;
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_wr_en <= (state_nxt == WRITE);
      gnt        <= do_gnt ? (ONE << winner) : '0;
      if (do_win) begin
        last_winner  <= win_idx;
        winner       <= win_idx;
        hold         <= win_word;
        fifo_data_in <= win_word;
      end else if (state == RETRY && state_nxt == WRITE) begin
        fifo_data_in <= hold;
      end
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // saturating counters of committed writes and retries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count    <= '0;
      retry_count <= '0;
    end else begin
      if (do_gnt && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      if (state == CHECK && state_nxt == RETRY &&
          retry_count != 16'hFFFF)
        retry_count <= retry_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter
// against a transaction-level round-robin model and word scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int SM_DIR   = 0;
  localparam int SM_RAND  = 1;
  localparam int SM_DRAIN = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]    wr_count;
  logic [15:0]    retry_count;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int smode = SM_DIR;
  int resp_mode = 0;
  int rate = 30;
  int ovf_req = 0;
  int m_grants = 0;
  int m_retries = 0;
  logic main_full = 1'b0;
  logic [N-1:0] dir_req = '0;
  logic [W-1:0] dir_word [N];
  logic [W-1:0] exp_q [N][$];

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_ack  (fifo_wr_ack),
    .fifo_overflow(fifo_overflow),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .wr_count     (wr_count),
    .retry_count  (retry_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int rr_pick(input logic [N-1:0] av, input int last);
    for (int k = 1; k <= N; k++)
      if (av[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // requesters: raise words, hold them until granted
  initial begin : stim
    logic [N-1:0] gs;
    logic [N-1:0] nreq;
    logic [W-1:0] word;
    int wcnt [N];
    bit nw;
    req = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    forever begin
      @(negedge clk);
      gs = gnt;
      @(posedge clk);
      #1;
      nreq = '0;
      for (int i = 0; i < N; i++) begin
        nw = 1'b0;
        case (smode)
          SM_DIR: begin
            nreq[i] = dir_req[i];
            nw = dir_req[i] && (!req[i] || gs[i]);
          end
          SM_RAND: begin
            if (req[i] && !gs[i]) begin
              nreq[i] = 1'b1;
            end else if (gs[i]) begin
              nreq[i] = ($urandom_range(0, 1) == 1);
              nw = nreq[i];
            end else begin
              nreq[i] = ($urandom_range(0, 99) < rate);
              nw = nreq[i];
            end
          end
          default: nreq[i] = req[i] && !gs[i];
        endcase
        if (nw) begin
          word = (smode == SM_DIR) ? dir_word[i]
                                   : {4'(i), 12'($urandom)};
          req_data[i*W +: W] = word;
          exp_q[i].push_back(word);
        end
        if (nreq[i] && !nw) wcnt[i]++;
        else wcnt[i] = 0;
        if (wcnt[i] == 400) fail_now($sformatf("starved_req%0d", i));
      end
      req = nreq;
    end
  end

  // FIFO write-side model: ack/overflow the cycle after wr_en
  initial begin : fifo_model
    bit w;
    bit a;
    bit o;
    int r;
    int full_cnt = 0;
    int ovf_done = 0;
    fifo_wr_ack = 1'b0;
    fifo_overflow = 1'b0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      w = fifo_wr_en;
      @(posedge clk);
      #1;
      a = 1'b0;
      o = 1'b0;
      if (w) begin
        if (resp_mode == 0) begin
          a = 1'b1;
        end else begin
          r = $urandom_range(0, 9);
          if (r < 6) a = 1'b1;
          else if (r < 8) o = 1'b1;
          else if (r == 9) begin a = 1'b1; o = 1'b1; end
          if (o && full_cnt == 0 && $urandom_range(0, 1) == 1)
            full_cnt = $urandom_range(1, 4);
        end
        if (ovf_done != ovf_req) begin
          ovf_done = ovf_req;
          a = 1'b0;
          o = 1'b1;
          full_cnt = 5;
        end
      end else if (resp_mode == 1 && full_cnt == 0 &&
                   $urandom_range(0, 19) == 0) begin
        full_cnt = $urandom_range(1, 3);
      end
      fifo_wr_ack = a;
      fifo_overflow = o;
      fifo_full = main_full || (full_cnt > 0);
      if (full_cnt > 0) full_cnt--;
    end
  end

  // monitor: transaction model of arbitration, retry and grant
  initial begin : monitor
    int m_last = N - 1;
    int nxt_gnt = -1;
    int cur_idx = 0;
    int w;
    bit inflight = 1'b0;
    bit retry_next = 1'b0;
    bit p_w = 1'b0;
    bit p_idle = 1'b0;
    bit p_full = 1'b1;
    logic [N-1:0] p_avail = '0;
    logic [N-1:0] gmask;
    logic [N-1:0] e;
    logic [W-1:0] cur_word = '0;
    logic [W-1:0] ew;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_last = N - 1;
        nxt_gnt = -1;
        inflight = 1'b0;
        retry_next = 1'b0;
        p_w = 1'b0;
        p_idle = 1'b0;
        m_grants = 0;
        m_retries = 0;
      end else begin
        gmask = '0;
        if (nxt_gnt >= 0) begin
          e = '0;
          e[nxt_gnt] = 1'b1;
          chk("gnt_onehot", gnt, e);
          if (exp_q[nxt_gnt].size() == 0) begin
            fail_now("commit_no_word");
          end else begin
            ew = exp_q[nxt_gnt].pop_front();
            chk("commit_word", cur_word, ew);
          end
          m_grants++;
          inflight = 1'b0;
          gmask[nxt_gnt] = 1'b1;
          nxt_gnt = -1;
        end else if (gnt != '0) begin
          chk("spurious_gnt", gnt, 0);
        end
        if (p_idle && p_avail != '0 && !p_full)
          chk("prompt_win", fifo_wr_en, 1);
        if (fifo_wr_en) begin
          chk("wr_while_full", p_full, 0);
          if (retry_next) begin
            chk("retry_word", fifo_data_in, cur_word);
            retry_next = 1'b0;
          end else begin
            w = rr_pick(p_avail, m_last);
            if (!p_idle || w < 0) begin
              fail_now("unexpected_write");
            end else begin
              m_last = w;
              cur_idx = w;
              inflight = 1'b1;
              if (exp_q[w].size() == 0) fail_now("win_no_word");
              else chk("win_word", fifo_data_in, exp_q[w][0]);
            end
            cur_word = fifo_data_in;
          end
        end
        if (p_w) begin
          if (fifo_overflow || !fifo_wr_ack) begin
            retry_next = 1'b1;
            m_retries++;
          end else begin
            nxt_gnt = cur_idx;
          end
        end
        p_w = fifo_wr_en;
        p_full = fifo_full;
        p_idle = !inflight;
        p_avail = req & ~gmask;
      end
    end
  end

  task automatic wait_gnt(output logic [N-1:0] g, output bit ok);
    ok = 1'b0;
    g = '0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("gnt_timeout");
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wr_timeout");
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    smode = SM_DRAIN;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      if (req == '0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
    dir_req = '0;
    smode = SM_DIR;
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    logic [N-1:0] g;
    logic [N-1:0] e;
    bit ok;
    int cprev;
    int nwr;
    int nb;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) dir_word[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_busy", busy, 0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst_wr_count", wr_count, 0);
    chk("rst_retry_count", retry_count, 0);
`endif
    nwr = 0;
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      nwr += int'(fifo_wr_en);
      nb += int'(busy);
    end
    chk("idle_no_write", nwr, 0);
    chk("idle_no_busy", nb, 0);

    for (int i = 0; i < N; i++) dir_word[i] = 16'hC000 | 16'(i);
    dir_req = '1;
    cprev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(g, ok);
      if (ok) begin
        e = '0;
        e[k % N] = 1'b1;
        chk("rr_order", g, e);
        if (k > 0) chk("rr_spacing", cyc - cprev, 3);
        cprev = cyc;
      end
    end
    drain();

    dir_word[1] = 16'hA5A5;
    dir_req = 4'b0010;
    wait_wr(ok);
    if (ok) begin
      chk("single_data", fifo_data_in, 16'hA5A5);
      @(negedge clk);
      chk("single_wr_pulse", fifo_wr_en, 0);
      chk("single_data_hold", fifo_data_in, 16'hA5A5);
      @(negedge clk);
      chk("single_gnt", gnt, 4'b0010);
    end
    dir_req = '0;
    repeat (3) @(negedge clk);

    dir_word[2] = 16'h2BEE;
    ovf_req++;
    dir_req = 4'b0100;
    nwr = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      nwr += int'(fifo_wr_en);
      if (gnt != '0) break;
    end
    chk("ovf_gnt", gnt, 4'b0100);
    chk("ovf_writes", nwr, 2);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("ovf_retry_count", retry_count, 1);
`endif
    dir_req = '0;
    repeat (3) @(negedge clk);

    main_full = 1'b1;
    repeat (2) @(negedge clk);
    dir_word[0] = 16'h0F0F;
    dir_req = 4'b0001;
    nwr = 0;
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      nwr += int'(fifo_wr_en);
      nb += int'(busy);
    end
    chk("full_no_write", nwr, 0);
    chk("full_no_busy", nb, 0);
    main_full = 1'b0;
    @(negedge clk);
    chk("full_drop_idle", busy, 0);
    @(negedge clk);
    chk("full_drop_win", fifo_wr_en, 1);
    chk("full_drop_data", fifo_data_in, 16'h0F0F);
    wait_gnt(g, ok);
    if (ok) chk("full_gnt", g, 4'b0001);
    dir_req = '0;
    repeat (3) @(negedge clk);

    resp_mode = 1;
    smode = SM_RAND;
    repeat (3000) @(negedge clk);
    drain();
    resp_mode = 0;

    for (int i = 0; i < N; i++) dir_word[i] = 16'h5000 | 16'(i);
    dir_req = '1;
    wait_wr(ok);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_en", fifo_wr_en, 0);
    chk("rst_mid_gnt", gnt, 0);
    wait_wr(ok);
    if (ok) chk("rst_mid_first", fifo_data_in, 16'h5000);
    drain();

`ifdef FIFO_WR_ARB_STATS_EN
    chk("final_wr_count", wr_count, 16'(m_grants));
    chk("final_retry_count", retry_count, 16'(m_retries));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
